// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//
// Control stage that drives the 2-bit select of a 4:1 mux. It steps through
// the enabled channels in ascending order, waits SETTLE_CYCLES on each one,
// samples the mux output, and hands the assembled 4-bit word downstream.
// Scanning is single-shot, or continuous until reset.
//
// Handshake: word_valid rises together with a new word. word and word_valid
// then hold stable until the consumer raises word_ready. A transfer happens
// on any rising clk edge where word_valid && word_ready are both high, and
// word_valid drops in the following cycle. word_ready has no effect while
// word_valid is low.
//
// Parameters:
//   SETTLE_CYCLES  cycles held on a channel before sampling (1..15)
//   CNT_W          settle counter width, 2**CNT_W > SETTLE_CYCLES
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse that begins a scan (honoured in IDLE only)
//   cont         sampled with start; 1 = rescan after every accepted word
//   en_mask[3:0] channel enables, latched when start is accepted
//   mux_f        output of the 4:1 mux
//   sel[1:0]     registered mux select
//   word[3:0]    captured word, bit i = channel i, disabled channels read 0
//   word_valid   word available
//   word_ready   consumer accepts the word
//   busy         high in every state except IDLE
//   word_parity  XOR of word bits (only when MUX_SCAN_PARITY_EN is defined)
//
// Build option: define MUX_SCAN_PARITY_EN to add the word_parity output.
//
// The FSM state is held in state_q (type state_t) so that checkers can bind
// to it directly.

module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic [3:0] en_mask,
    input  logic       mux_f,
    output logic [1:0] sel,
    output logic [3:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       word_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        EMIT   = 2'd3
    } state_t;

    // Counter value seen on the last settle cycle of a channel.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic             cont_q, cont_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [1:0]       sel_d;
    logic [3:0]       word_d;
    logic             valid_d;
    logic [3:0]       captured;
    logic [2:0]       next_info;

    // Lowest set bit of a non-zero mask.
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // {found, index} of the lowest enabled channel strictly above cur.
    function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    // Shadow with the bit for the current channel replaced by the mux output.
    // Used both to update the shadow and, on the last channel, to load the
    // output word in the same edge so no extra cycle is spent.
    always_comb begin
        captured      = shadow_q;
        captured[sel] = mux_f;
    end

    assign next_info = next_ch(mask_q, sel);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        cont_d   = cont_q;
        shadow_d = shadow_q;
        sel_d    = sel;
        word_d   = word;
        valid_d  = word_valid;

        case (state_q)
            IDLE: begin
                if (start && (en_mask != 4'h0)) begin
                    state_d  = SETTLE;
                    mask_d   = en_mask;
                    cont_d   = cont;
                    shadow_d = 4'h0;
                    sel_d    = lowest_ch(en_mask);
                    cnt_d    = '0;
                end
            end

            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                shadow_d = captured;
                if (next_info[2]) begin
                    sel_d   = next_info[1:0];
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    word_d  = captured;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end

            EMIT: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    if (cont_q) begin
                        // Restart from the latched mask; cont stays latched
                        // until reset.
                        state_d  = SETTLE;
                        sel_d    = lowest_ch(mask_q);
                        shadow_d = 4'h0;
                        cnt_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mask_q     <= 4'h0;
            cont_q     <= 1'b0;
            shadow_q   <= 4'h0;
            sel        <= 2'b00;
            word       <= 4'h0;
            word_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            cont_q     <= cont_d;
            shadow_q   <= shadow_d;
            sel        <= sel_d;
            word       <= word_d;
            word_valid <= valid_d;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_parity <= 1'b0;
        end else begin
            word_parity <= ^word_d;
        end
    end
`endif

    assign busy = (state_q != IDLE);

endmodule
